// File: rtl/dly_pkg.sv
// Shared constants and elaboration helpers for the pulse delay-line blocks.
package dly_pkg;

   localparam int DLY_DEFAULT_DELAY = 10;
   localparam int DLY_DEFAULT_W     = 8;
   localparam int DLY_DEFAULT_DEPTH = 4;

   // A delay must fit strictly inside one lap of the W-bit timestamp.
   function automatic bit delay_legal(input int delay, input int w);
      longint lim;
      lim = longint'(1) << w;
      return (delay >= 1) && (longint'(delay) < lim);
   endfunction

   function automatic bit is_pow2(input int depth);
      return (depth >= 1) && ((depth & (depth - 1)) == 0);
   endfunction

   function automatic int pend_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dly_fifo.sv
// Expiry-time FIFO: exposes the head and the entry behind it so the owner can
// look one pop ahead. Flush empties the queue but still takes a same-cycle push.
module dly_fifo
   import dly_pkg::*;
#(
   parameter int W     = DLY_DEFAULT_W,
   parameter int DEPTH = DLY_DEFAULT_DEPTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic                          pop,
   input  logic                          flush,
   input  logic [W-1:0]                  wdata,
   output logic [W-1:0]                  head,
   output logic [W-1:0]                  second,
   output logic                          full,
   output logic                          empty,
   output logic [pend_width(DEPTH)-1:0]  count
);

   localparam int AW = addr_width(DEPTH);
   localparam int CW = pend_width(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic          do_pop, do_push;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] a);
      return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (flush || !full || do_pop);
   assign head    = mem[rd_ptr];
   assign second  = mem[inc(rd_ptr)];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         wr_ptr <= push ? inc(wr_ptr) : wr_ptr;
         count  <= push ? CW'(1) : '0;
      end else begin
         if (do_pop)
            rd_ptr <= inc(rd_ptr);
         if (do_push)
            wr_ptr <= inc(wr_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage is data only and needs no reset.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/dly_queue.sv
// Multi-pulse delay line: each accepted trigger reappears on p exactly DELAY
// cycles later, tracked as absolute expiry stamps against a free-running counter.
module dly_queue
   import dly_pkg::*;
#(
   parameter int DELAY   = DLY_DEFAULT_DELAY,
   parameter int W       = DLY_DEFAULT_W,
   parameter int DEPTH   = DLY_DEFAULT_DEPTH,
   parameter int RESTART = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in,
   input  logic                          clr,
   output logic                          p,
   output logic                          busy,
   output logic [pend_width(DEPTH)-1:0]  pend,
   output logic                          ovf
);

   localparam int CW = pend_width(DEPTH);

   if (!delay_legal(DELAY, W)) begin : g_bad_delay
      $error("dly_queue: DELAY must lie in 1..2**W-1");
   end
   if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("dly_queue: DEPTH must be a power of 2");
   end

   logic [W-1:0] now, head, second, expiry, nxt_head;
   logic         full, empty, match, pop, flush, push, drop;
   logic         nxt_valid, p_next;

   assign expiry = now + W'(DELAY);
   assign match  = !empty && (head == now);
   assign flush  = (RESTART != 0) && in;
   assign pop    = match && !flush;
   assign push   = in && (flush || !full || pop);
   assign drop   = in && !push;
   assign busy   = (pend != '0);

   dly_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (push),
      .pop    (pop),
      .flush  (flush),
      .wdata  (expiry),
      .head   (head),
      .second (second),
      .full   (full),
      .empty  (empty),
      .count  (pend)
   );

   // p is registered, so it is raised one cycle ahead: work out which entry
   // will be at the head next cycle and whether it expires then.
   always_comb begin
      nxt_valid = 1'b0;
      nxt_head  = expiry;
      if (flush) begin
         nxt_valid = 1'b1;
         nxt_head  = expiry;
      end else if (pop && (pend > CW'(1))) begin
         nxt_valid = 1'b1;
         nxt_head  = second;
      end else if (!pop && !empty) begin
         nxt_valid = 1'b1;
         nxt_head  = head;
      end else if (push) begin
         nxt_valid = 1'b1;
         nxt_head  = expiry;
      end
   end

   assign p_next = nxt_valid && (nxt_head == now + W'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         now <= '0;
         p   <= 1'b0;
         ovf <= 1'b0;
      end else begin
         now <= now + W'(1);
         p   <= p_next;
         ovf <= clr ? drop : (ovf | drop);
      end
   end

endmodule
